game_supervisor: RTL
====================

# game_supervisor

Parametrised game-state supervisor for multi-player snake. It owns the global play state: idle, run, pause, game over and win. It gates the per-frame tick enable, latches per-player death and win, and keeps saturating per-player scores. It sits between the control/snake/apple instances and the tick generator, VGA and sound blocks, and replaces the ad-hoc failure/success latches of the single-player top.

## Interface
Parameters:
- PLAYERS, 2: number of snakes, 1..4.
- SCORE_W, 8: score counter width per player.
- WIN_SCORE, 200: score at which a player wins; must be < 2**SCORE_W.
- AUTO_FRAMES, 180: frames spent in OVER/WIN before auto restart; only used with GAME_AUTO_RESTART_EN.

Ports (clk, rst_n: reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_restart  in  1  synchronous restart, level
- i_pause  in  1  pause toggle, one-cycle pulse
- i_start  in  PLAYERS  per-player first-input pulse
- i_vsync  in  1  frame pulse, one cycle per frame
- i_failure  in  PLAYERS  snake collision pulse
- i_success  in  PLAYERS  snake board-full pulse
- i_eat  in  PLAYERS  apple-eaten pulse
- o_state  out  3  IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4
- o_frame_en  out  1  gated frame pulse for the tick generator
- o_game_rst_n  out  1  active-low reset for game sub-blocks
- o_alive  out  PLAYERS  player still alive
- o_winner  out  PLAYERS  player won
- o_score  out  PLAYERS*SCORE_W  scores; player p occupies bits [p*SCORE_W +: SCORE_W]
- o_fail_evt  out  1  one-cycle pulse on entry to OVER
- o_win_evt  out  1  one-cycle pulse on entry to WIN

## Operation
- **Restart condition.** Call it R: !rst_n or i_restart.
- **Reset/restart values.** While R holds, all outputs take these values on the next edge: state IDLE, o_alive all ones, o_winner 0, scores 0, o_frame_en 0, both evt 0, auto counter 0.
- **o_game_rst_n.** Registered !R. It is low for every cycle following a cycle with R high.
- **IDLE.**
  - Any i_start bit high -> RUN.
  - i_pause is ignored.
  - failure/success/eat are ignored.
- **RUN.**
  - i_pause -> PAUSE.
  - Events are processed as described under "Event processing".
- **PAUSE.**
  - i_pause -> RUN.
  - Events are still processed, so in-flight snake results are not lost.
- **Event processing** (each cycle, RUN or PAUSE):
  - F = i_failure & o_alive.
  - S = i_success & o_alive & ~F.
  - E = i_eat & o_alive & ~F.
  - alive_next = o_alive & ~F.
  - Score of each player in E increments by 1 and saturates at all-ones.
  - Score win set: W = S | {p in E : score_p + 1 >= WIN_SCORE}.
  - If W != 0: o_winner <= W, state -> WIN, o_win_evt pulses. Win takes precedence over OVER and over a pause pulse in the same cycle.
  - Else if alive_next == 0: state -> OVER, o_fail_evt pulses.
  - PLAYERS=1 degenerates to the single-player game.
- **OVER / WIN.**
  - Terminal states: scores, o_alive and o_winner are frozen.
  - Only R (or auto restart) leaves them.
- **Frame gating.** o_frame_en <= i_vsync && state==RUN. Evaluation uses the current registered state.

## Timing
- All outputs are registered.
- Event-to-state/score/alive latency is 1 cycle.
- evt pulses are high exactly in the first cycle that o_state shows OVER/WIN.
- i_vsync to o_frame_en latency is 1 cycle, with width 1.
- A pause pulse and i_vsync in the same cycle while in RUN: o_frame_en still fires, because the state was RUN.
- R mid-operation overrides every other input in the same cycle.

## Configuration
- **GAME_AUTO_RESTART_EN defined.**
  - In OVER/WIN, a counter of width $clog2(AUTO_FRAMES+1) counts i_vsync pulses.
  - On reaching AUTO_FRAMES, the next edge applies full restart values and drives o_game_rst_n low for 1 cycle, exactly as if R had been asserted.
  - The counter clears on leaving OVER/WIN.
- **GAME_AUTO_RESTART_EN undefined.**
  - No counter exists.
  - OVER/WIN persist until R.

## Test plan
- **Start.** Reset, then i_start=2'b10 -> o_state=1 next cycle. i_vsync pulse -> o_frame_en=1 for exactly one cycle, one cycle later.
- **Pause.** RUN, then i_pause -> state 2, and subsequent i_vsync produces no o_frame_en. i_eat[0] in PAUSE -> score0 = 1. Second i_pause -> state 1.
- **Death and game over.** PLAYERS=2: i_failure=01 -> o_alive=10, state stays RUN. Then i_failure=11 -> o_alive=00, state 3, o_fail_evt high 1 cycle. Further i_eat leaves scores unchanged.
- **Same-cycle success and failure.** i_failure=01 with i_success=11 -> o_winner=10, state 4, o_win_evt 1 cycle, o_fail_evt stays 0.
- **Score win and saturation.** Score1=199: i_eat=10 -> score1=200, state WIN, o_winner=10. Separately, with WIN_SCORE=255 and SCORE_W=8, score 255 plus an eat stays 255.
- **Restart and auto restart.** i_restart in WIN -> next cycle state 0, scores 0, o_alive=11, o_game_rst_n=0 for 1 cycle. With GAME_AUTO_RESTART_EN and AUTO_FRAMES=3: in OVER, the 3rd i_vsync -> state 0 next cycle. Without the macro, 10 vsyncs -> state remains 3.

Source files
------------

// File: rtl/game_supervisor.sv
// Multi-player snake play-state supervisor: gates frame ticks, latches death/win, keeps saturating scores.
// All outputs registered, 1-cycle latency, no backpressure; define GAME_AUTO_RESTART_EN for auto restart.
module game_supervisor #(
    parameter int PLAYERS     = 2,
    parameter int SCORE_W     = 8,
    parameter int WIN_SCORE   = 200,
    parameter int AUTO_FRAMES = 180
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_restart,
    input  logic                       i_pause,
    input  logic [PLAYERS-1:0]         i_start,
    input  logic                       i_vsync,
    input  logic [PLAYERS-1:0]         i_failure,
    input  logic [PLAYERS-1:0]         i_success,
    input  logic [PLAYERS-1:0]         i_eat,
    output logic [2:0]                 o_state,
    output logic                       o_frame_en,
    output logic                       o_game_rst_n,
    output logic [PLAYERS-1:0]         o_alive,
    output logic [PLAYERS-1:0]         o_winner,
    output logic [PLAYERS*SCORE_W-1:0] o_score,
    output logic                       o_fail_evt,
    output logic                       o_win_evt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } state_t;

    localparam logic [SCORE_W:0] WIN_L = (SCORE_W+1)'(WIN_SCORE);

    state_t                         state_q, state_d;
    logic [PLAYERS-1:0]             alive_q, alive_d, winner_q, winner_d;
    logic [PLAYERS-1:0][SCORE_W-1:0] score_q, score_d, score_ev;
    logic [PLAYERS-1:0]             fail_v, succ_v, eat_v, alive_nx, win_set;
    logic                           frame_en_q, fail_evt_q, fail_evt_d, win_evt_q, win_evt_d;
    logic                           game_rst_n_q;
    logic                           auto_fire;
    logic                           restart;
    logic                           terminal;

    assign terminal = (state_q == ST_OVER) || (state_q == ST_WIN);

`ifdef GAME_AUTO_RESTART_EN
    localparam int CNT_W = $clog2(AUTO_FRAMES + 1);
    logic [CNT_W-1:0] auto_cnt_q;

    // Fires on the vsync that brings the count up to AUTO_FRAMES.
    assign auto_fire = terminal && i_vsync && (auto_cnt_q == CNT_W'(AUTO_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || i_restart || auto_fire || !terminal) begin
            auto_cnt_q <= '0;
        end else if (i_vsync) begin
            auto_cnt_q <= auto_cnt_q + CNT_W'(1);
        end
    end
`else
    logic auto_unused;
    assign auto_unused = (AUTO_FRAMES > 0);
    assign auto_fire   = 1'b0;
`endif

    assign restart = !rst_n || i_restart || auto_fire;

    always_comb begin
        fail_v   = i_failure & alive_q;
        succ_v   = i_success & alive_q & ~fail_v;
        eat_v    = i_eat & alive_q & ~fail_v;
        alive_nx = alive_q & ~fail_v;
        win_set  = succ_v;
        score_ev = score_q;
        for (int p = 0; p < PLAYERS; p++) begin
            if (eat_v[p]) begin
                if (score_q[p] != '1) begin
                    score_ev[p] = score_q[p] + SCORE_W'(1);
                end
                if (({1'b0, score_q[p]} + (SCORE_W+1)'(1)) >= WIN_L) begin
                    win_set[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        alive_d    = alive_q;
        winner_d   = winner_q;
        score_d    = score_q;
        fail_evt_d = 1'b0;
        win_evt_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_PAUSE: begin
                alive_d = alive_nx;
                score_d = score_ev;
                // Win beats game over, which beats a pause toggle.
                if (|win_set) begin
                    winner_d  = win_set;
                    state_d   = ST_WIN;
                    win_evt_d = 1'b1;
                end else if (alive_nx == '0) begin
                    state_d    = ST_OVER;
                    fail_evt_d = 1'b1;
                end else if (i_pause) begin
                    state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        game_rst_n_q <= !restart;
        if (restart) begin
            state_q    <= ST_IDLE;
            alive_q    <= '1;
            winner_q   <= '0;
            score_q    <= '0;
            frame_en_q <= 1'b0;
            fail_evt_q <= 1'b0;
            win_evt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= alive_d;
            winner_q   <= winner_d;
            score_q    <= score_d;
            frame_en_q <= i_vsync && (state_q == ST_RUN);
            fail_evt_q <= fail_evt_d;
            win_evt_q  <= win_evt_d;
        end
    end

    assign o_state      = state_q;
    assign o_frame_en   = frame_en_q;
    assign o_game_rst_n = game_rst_n_q;
    assign o_alive      = alive_q;
    assign o_winner     = winner_q;
    assign o_score      = score_q;
    assign o_fail_evt   = fail_evt_q;
    assign o_win_evt    = win_evt_q;

endmodule
